// File: rtl/datapath_sequencer.sv
// datapath_sequencer: Moore control FSM that walks the lab-4 datapath through clear, load, compute and write.
// Optional feature macro DATAPATH_SEQUENCER_STEP_MODE_EN adds a step input that gates advancement and register loads.
module datapath_sequencer #(
  parameter int unsigned CLR_CYCLES  = 2,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
`ifdef DATAPATH_SEQUENCER_STEP_MODE_EN
  input  logic       step,
`endif
  output logic       dp_clear,
  output logic [2:0] w,
  output logic [3:0] ce,
  output logic [1:0] sel,
  output logic [2:0] s,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    LD1  = 3'd2,
    LD4A = 3'd3,
    LD2  = 3'd4,
    LD4B = 3'd5,
    WR3  = 3'd6,
    HOLD = 3'd7
  } state_t;

  localparam logic [7:0] CLR_LOAD  = 8'(CLR_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t     state_r, state_next_s;
  logic [7:0] cnt_r, cnt_next_s;
  logic       cnt_zero_s;
  logic       adv_s;
  logic       dp_clear_s, done_s;
  logic [2:0] w_s, s_s;
  logic [3:0] ce_s;
  logic [1:0] sel_s;

`ifdef DATAPATH_SEQUENCER_STEP_MODE_EN
  assign adv_s = step;
`else
  assign adv_s = 1'b1;
`endif

  assign cnt_zero_s = (cnt_r == 8'd0);

  // State and counter registers; clear aborts a run without waiting for an edge
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state and counter update; non-IDLE states only move on an advance cycle
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = CLR;
          cnt_next_s   = CLR_LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      CLR: begin
        if (adv_s && cnt_zero_s) begin
          state_next_s = LD1;
        end else if (adv_s) begin
          cnt_next_s = cnt_r - 8'd1;
        end else begin
          state_next_s = CLR;
        end
      end
      LD1:  state_next_s = adv_s ? LD4A : LD1;
      LD4A: state_next_s = adv_s ? LD2  : LD4A;
      LD2:  state_next_s = adv_s ? LD4B : LD2;
      LD4B: state_next_s = adv_s ? WR3  : LD4B;
      WR3: begin
        if (adv_s) begin
          state_next_s = HOLD;
          cnt_next_s   = HOLD_LOAD;
        end else begin
          state_next_s = WR3;
        end
      end
      HOLD: begin
        if (adv_s && cnt_zero_s) begin
          state_next_s = IDLE;
        end else if (adv_s) begin
          cnt_next_s = cnt_r - 8'd1;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 8'd0;
      end
    endcase
  end

  // Moore decode of the registered state, before step qualification
  always_comb begin
    dp_clear_s = 1'b0;
    w_s        = 3'b000;
    ce_s       = 4'b0000;
    sel_s      = 2'b00;
    s_s        = 3'b000;
    done_s     = 1'b0;
    case (state_r)
      IDLE: dp_clear_s = 1'b0;
      CLR:  dp_clear_s = 1'b1;
      LD1: begin
        ce_s = 4'b0001;
        s_s  = 3'd2;
      end
      LD4A: begin
        ce_s = 4'b1000;
        s_s  = 3'd2;
      end
      LD2: begin
        ce_s  = 4'b0010;
        sel_s = 2'd1;
        s_s   = 3'd1;
      end
      LD4B: begin
        ce_s  = 4'b1000;
        sel_s = 2'd1;
        s_s   = 3'd1;
      end
      WR3: begin
        ce_s  = 4'b0100;
        w_s   = 3'b100;
        sel_s = 2'd1;
        s_s   = 3'd1;
      end
      HOLD: begin
        w_s    = 3'b100;
        sel_s  = 2'd1;
        s_s    = 3'd1;
        done_s = cnt_zero_s;
      end
      default: dp_clear_s = 1'b0;
    endcase
  end

  // Register loads and the done pulse happen once per advance; w, sel and s follow the raw state
  assign dp_clear = dp_clear_s & adv_s;
  assign ce       = ce_s & {4{adv_s}};
  assign done     = done_s & adv_s;
  assign w        = w_s;
  assign sel      = sel_s;
  assign s        = s_s;
  assign busy     = (state_r != IDLE);
  assign state    = state_r;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: two instances (default and CLR=3/HOLD=4) under random start and mid-run clear.
module tb_datapath_sequencer;

  typedef logic [17:0] rec_t;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
`ifdef DATAPATH_SEQUENCER_STEP_MODE_EN
  logic       step  = 1'b1;
`endif

  logic       dpc0, busy0, done0, dpc1, busy1, done1;
  logic [2:0] w0, s0, st0, w1, s1, st1;
  logic [3:0] ce0, ce1;
  logic [1:0] sel0, sel1;

  int   errors = 0;
  int   checks = 0;
  rec_t q0[$];
  rec_t q1[$];
  int   left0 = 0;
  int   left1 = 0;

  always #5 clock = ~clock;

  datapath_sequencer u0 (
    .clock(clock), .clear(clear), .start(start),
`ifdef DATAPATH_SEQUENCER_STEP_MODE_EN
    .step(step),
`endif
    .dp_clear(dpc0), .w(w0), .ce(ce0), .sel(sel0), .s(s0),
    .busy(busy0), .done(done0), .state(st0)
  );

  datapath_sequencer #(.CLR_CYCLES(3), .HOLD_CYCLES(4)) u1 (
    .clock(clock), .clear(clear), .start(start),
`ifdef DATAPATH_SEQUENCER_STEP_MODE_EN
    .step(step),
`endif
    .dp_clear(dpc1), .w(w1), .ce(ce1), .sel(sel1), .s(s1),
    .busy(busy1), .done(done1), .state(st1)
  );

  wire rec_t obs0 = {st0, dpc0, w0, ce0, sel0, s0, busy0, done0};
  wire rec_t obs1 = {st1, dpc1, w1, ce1, sel1, s1, busy1, done1};

  task automatic check(input string name, input int i, input rec_t got, input rec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got st=%0d dpc=%b w=%b ce=%b sel=%0d s=%0d busy=%b done=%b | exp st=%0d dpc=%b w=%b ce=%b sel=%0d s=%0d busy=%b done=%b",
               name, i, $time, got[17:15], got[14], got[13:11], got[10:7], got[6:5], got[4:2], got[1], got[0],
               exp[17:15], exp[14], exp[13:11], exp[10:7], exp[6:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  function automatic rec_t row(input logic [2:0] st, input logic dpc, input logic [2:0] w,
                               input logic [3:0] ce, input logic [1:0] sel, input logic [2:0] s,
                               input logic dn);
    return {st, dpc, w, ce, sel, s, 1'b1, dn};
  endfunction

  task automatic push(input int i, input rec_t r);
    if (i == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Whole expected run: clear phase, four loads, write, then the hold phase ending in done
  task automatic push_run(input int i);
    int cc = (i == 0) ? 2 : 3;
    int hc = (i == 0) ? 1 : 4;
    for (int c = 0; c < cc; c++) push(i, row(3'd1, 1'b1, 3'b000, 4'b0000, 2'd0, 3'd0, 1'b0));
    push(i, row(3'd2, 1'b0, 3'b000, 4'b0001, 2'd0, 3'd2, 1'b0));
    push(i, row(3'd3, 1'b0, 3'b000, 4'b1000, 2'd0, 3'd2, 1'b0));
    push(i, row(3'd4, 1'b0, 3'b000, 4'b0010, 2'd1, 3'd1, 1'b0));
    push(i, row(3'd5, 1'b0, 3'b000, 4'b1000, 2'd1, 3'd1, 1'b0));
    push(i, row(3'd6, 1'b0, 3'b100, 4'b0100, 2'd1, 3'd1, 1'b0));
    for (int h = 0; h < hc; h++) push(i, row(3'd7, 1'b0, 3'b100, 4'b0000, 2'd1, 3'd1, (h == hc - 1)));
  endtask

  // One rising edge plus the reference model's view of what each instance did at it
  task automatic tick();
    @(posedge clock);
    if (clear) begin
      left0 = 0;
      left1 = 0;
    end else begin
      if (left0 == 0 && start) begin push_run(0); left0 = 8; end
      else if (left0 > 0) left0--;
      if (left1 == 0 && start) begin push_run(1); left1 = 12; end
      else if (left1 > 0) left1--;
    end
  endtask

  // Monitor: each cycle the outputs must equal the next expected row, or the idle pattern when none is pending
  always @(negedge clock) begin
    rec_t e0, e1;
    e0 = '0;
    e1 = '0;
    if (q0.size() > 0) e0 = q0.pop_front();
    if (q1.size() > 0) e1 = q1.pop_front();
    check("cycle", 0, obs0, e0);
    check("cycle", 1, obs1, e1);
  end

  initial begin
    bit found;
    clear = 1'b1;
    start = 1'b0;
    repeat (2) tick();
    #1;
    check("reset", 0, obs0, '0);
    check("reset", 1, obs1, '0);
    clear = 1'b0;

    // random start requests, mostly short pulses
    for (int n = 0; n < 400; n++) begin
      tick();
      #1 start = ($urandom_range(0, 3) == 0);
    end

    // start held high: runs back to back with a single idle cycle between
    for (int n = 0; n < 50; n++) begin
      tick();
      #1 start = 1'b1;
    end
    tick();
    #1 start = 1'b0;
    repeat (20) tick();

    // abort mid-run while the default instance sits in LD2
    #1 start = 1'b1;
    tick();
    #1 start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      #2;
      if (st0 == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_ld2 dut0 t=%0t got st=%0d exp st=4", $time, st0);
    end
    clear = 1'b1;
    q0.delete();
    q1.delete();
    left0 = 0;
    left1 = 0;
    #1;
    check("abort", 0, obs0, '0);
    check("abort", 1, obs1, '0);
    repeat (3) tick();
    #1 clear = 1'b0;
    repeat (15) tick();

    // a clean run after the abort
    #1 start = 1'b1;
    tick();
    #1 start = 1'b0;
    repeat (20) tick();

    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
